// File: rtl/sr_pkg.sv
// sr_pkg: shared definitions for the iterative right shifter.
//   WIDTH_DEF / SHW_DEF : default operand width and shift-amount width.
//   sr_state_t          : controller states (IDLE, SHIFT, DONE).
package sr_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned SHW_DEF   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sr_state_t;

endpackage

// File: rtl/sr_step.sv
// sr_step: combinational single-step right shift.
// Optional feature macro: SR_ITER_FAST4_EN (adds a 4-bit step selected by by4).
// Ports:
//   in   : operand
//   fill : bit shifted in at the MSB end
//   en   : 1 = shift, 0 = pass in through unchanged
//   by4  : (SR_ITER_FAST4_EN only) 1 = shift by 4, 0 = shift by 1
//   out  : shifted result
module sr_step
    import sr_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] in,
    input  logic             fill,
    input  logic             en,
`ifdef SR_ITER_FAST4_EN
    input  logic             by4,
`endif
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = in;
        if (en) begin
`ifdef SR_ITER_FAST4_EN
            if (by4) begin
                out = {{4{fill}}, in[WIDTH-1:4]};
            end else begin
                out = {fill, in[WIDTH-1:1]};
            end
`else
            out = {fill, in[WIDTH-1:1]};
`endif
        end
    end

endmodule

// File: rtl/sr_iter.sv
// sr_iter: iterative logical/arithmetic right shifter, one step per clock.
// Optional feature macro: SR_ITER_FAST4_EN (shift by 4 per cycle while cnt >= 4).
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   start : request, accepted only when idle
//   in    : operand, sampled on accept
//   shamt : shift amount, sampled on accept
//   arith : 1 = sign fill, 0 = zero fill, sampled on accept
//   busy  : high whenever not idle (registered)
//   done  : one-cycle pulse, outp valid in that cycle (registered)
//   outp  : result register, holds last result until the next done
module sr_iter
    import sr_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned SHW   = SHW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   shamt,
    input  logic             arith,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] outp
);

    sr_state_t        state;
    logic [WIDTH-1:0] data_r;
    logic [SHW-1:0]   cnt;
    logic             arith_r;

    logic [WIDTH-1:0] step_out;
    logic             step_en;
    logic             fill;
    logic [SHW-1:0]   cnt_dec;

    assign step_en = (state == SHIFT) && (cnt != '0);
    assign fill    = arith_r & data_r[WIDTH-1];

`ifdef SR_ITER_FAST4_EN
    logic by4;
    assign by4     = (cnt >= SHW'(4));
    assign cnt_dec = by4 ? SHW'(4) : SHW'(1);
`else
    assign cnt_dec = SHW'(1);
`endif

    sr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .in   (data_r),
        .fill (fill),
        .en   (step_en),
`ifdef SR_ITER_FAST4_EN
        .by4  (by4),
`endif
        .out  (step_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            data_r  <= '0;
            cnt     <= '0;
            arith_r <= 1'b0;
            outp    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        data_r  <= in;
                        cnt     <= shamt;
                        arith_r <= arith;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        data_r <= step_out;
                        cnt    <= cnt - cnt_dec;
                    end else begin
                        outp  <= data_r;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // busy stays high through the done cycle and drops on return to idle
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_iter.sv
// tb_sr_iter: randomized scoreboard bench for sr_iter.
module tb_sr_iter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] op_in;
    logic [4:0]  shamt;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] outp;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] last_res = '0;

    sr_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in    (op_in),
        .shamt (shamt),
        .arith (arith),
        .busy  (busy),
        .done  (done),
        .outp  (outp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    // Reference: plain shift operators; latency from the cycle-count formula.
    function automatic logic [31:0] ref_shift(input logic [31:0] a, input int n, input logic ar);
        logic signed [31:0] s;
        s = a;
        if (ar) return 32'(s >>> n);
        return a >> n;
    endfunction

    function automatic int ref_lat(input int n);
`ifdef SR_ITER_FAST4_EN
        return n / 4 + n % 4 + 2;
`else
        return n + 2;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 outp=%h", outp);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result", outp, e.res);
                check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                last_res = e.res;
            end
        end
    end

    task automatic do_op(input logic [31:0] a, input logic [4:0] n, input logic ar);
        exp_t e;
        int   t;
        t = 0;
        @(negedge clk);
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL busy_timeout actual=1 required=0");
        end
        start = 1'b1;
        op_in = a;
        shamt = n;
        arith = ar;
        e.res = ref_shift(a, int'(n), ar);
        e.lat = ref_lat(int'(n));
        e.acc = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        op_in = $urandom;
        shamt = 5'($urandom);
        arith = 1'($urandom);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || q.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (busy || q.size() != 0) begin
            failures++;
            $display("FAIL idle_timeout actual_busy=%0b pending=%0d required=0", busy, q.size());
        end
        repeat (2) @(negedge clk);
        check("outp_hold", outp, last_res);
        check("busy_idle", 32'(busy), 32'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op_in = '0;
        shamt = '0;
        arith = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_outp", outp, 32'h0);
        rst_n = 1'b1;

        // Directed cases
        do_op(32'h8000_0000, 5'd4, 1'b0);  wait_idle();
        do_op(32'h8000_0000, 5'd4, 1'b1);  wait_idle();
        do_op(32'h1234_5678, 5'd0, 1'b0);  wait_idle();
        do_op(32'h8000_0000, 5'd31, 1'b1); wait_idle();
        do_op(32'h8000_0000, 5'd31, 1'b0); wait_idle();

        // start while busy must be ignored
        do_op(32'hF000_0000, 5'd8, 1'b0);
        @(negedge clk);
        check("busy_during_op", 32'(busy), 32'(1));
        start = 1'b1;
        op_in = 32'hFFFF_FFFF;
        shamt = 5'd0;
        arith = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        check("ignored_start_result", outp, 32'h00F0_0000);

        // Back-to-back random ops
        for (int i = 0; i < 30; i++) begin
            do_op($urandom, 5'($urandom), 1'($urandom));
        end
        wait_idle();

        // Reset in the middle of a shift
        do_op(32'h8000_0000, 5'd20, 1'b1);
        repeat (4) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_busy", 32'(busy), 32'(0));
        check("midreset_done", 32'(done), 32'(0));
        check("midreset_outp", outp, 32'h0);
        q.delete();
        last_res = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_reset_busy", 32'(busy), 32'(0));
        do_op(32'hC000_0003, 5'd7, 1'b1);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
